booth_operand_sequencer: RTL and testbench

Front-end sequencer for the Booth multiplier datapath/controller pair. Accepts a multiplicand/multiplier pair over a valid/ready handshake and pulses `start`. It then serialises the two operands onto the multiplier's shared 16-bit `data_in` bus in the cycle order the controller loads them (M, then Q). It waits for `done`, captures the 32-bit `{A,Q}` product, and holds it on a valid/ready output port until consumed.

---
 rtl/booth_operand_sequencer_pkg.sv | 20 ++
 rtl/booth_operand_sequencer_if.sv | 33 +++
 rtl/booth_operand_sequencer_wait_timer.sv | 39 +++
 rtl/booth_operand_sequencer.sv | 135 +++++++++++++
 tb/tb_booth_operand_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_operand_sequencer_pkg.sv
// Shared types and defaults for the Booth multiplier front-end sequencer.
package booth_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LDM,
        LDQ,
        WAIT,
        OUT
    } seq_state_t;

    localparam int W_DEF       = 16;
    localparam int TIMEOUT_DEF = 40;

    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/booth_operand_sequencer_if.sv
// Operand-in, multiplier-side and result-out signals of the sequencer in one bundle.
interface booth_seq_if
    import booth_seq_pkg::*;
#(
    parameter int W = W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             start;
    logic [W-1:0]     data_in;
    logic             done;
    logic [2*W-1:0]   product;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_product;
    logic             out_err;
    logic             busy;

    // The sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, done, product, out_ready,
        output in_ready, start, data_in, out_valid, out_product, out_err, busy
    );

    // The surroundings: operand producer, multiplier and result consumer.
    modport master (
        output in_valid, in_a, in_b, done, product, out_ready,
        input  in_ready, start, data_in, out_valid, out_product, out_err, busy
    );

endinterface

// File: rtl/booth_operand_sequencer_wait_timer.sv
// Counts cycles spent waiting for the multiplier and flags the last allowed one.
module booth_wait_timer
    import booth_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            TW   = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Saturates at LAST so a stalled enable can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/booth_operand_sequencer.sv
// Feeds an operand pair to the Booth multiplier (start, M, Q), waits for done
// and presents the captured product (or a timeout abort) on a valid/ready port.
module booth_operand_sequencer
    import booth_seq_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    booth_seq_if.slave  bus
);
    seq_state_t     state_q, state_d;

    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   data_in_q, data_in_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic           out_err_q, out_err_d;
    logic [2*W-1:0] out_product_q, out_product_d;
    logic           done_low_seen_q, done_low_seen_d;

    logic           accept;
    logic           done_ok;
    logic           tmr_clr;
    logic           tmr_en;
    logic           tmr_expired;

    assign accept  = (state_q == IDLE) && bus.in_valid;
    // A done that was never seen low since start belongs to the previous operation.
    assign done_ok = (state_q == WAIT) && bus.done && done_low_seen_q;
    assign tmr_clr = (state_q == LDQ);
    assign tmr_en  = (state_q == WAIT);

    booth_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = LDM;
            LDM:     state_d = LDQ;
            LDQ:     state_d = WAIT;
            WAIT:    if (done_ok || tmr_expired) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        a_d             = a_q;
        b_d             = b_q;
        done_low_seen_d = done_low_seen_q;
        out_product_d   = out_product_q;
        out_err_d       = out_err_q;

        if (accept) begin
            a_d             = bus.in_a;
            b_d             = bus.in_b;
            done_low_seen_d = 1'b0;
        end else if ((state_q inside {START, LDM, LDQ, WAIT}) && !bus.done) begin
            done_low_seen_d = 1'b1;
        end

        if (done_ok) begin
            out_product_d = bus.product;
            out_err_d     = 1'b0;
        end else if (tmr_expired) begin
            out_product_d = '0;
            out_err_d     = 1'b1;
        end

        start_d     = (state_d == START);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);

        unique case (state_d)
            LDM:     data_in_d = a_q;
            LDQ:     data_in_d = b_q;
            default: data_in_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q             <= '0;
            b_q             <= '0;
            data_in_q       <= '0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            out_err_q       <= 1'b0;
            out_product_q   <= '0;
            done_low_seen_q <= 1'b0;
        end else begin
            a_q             <= a_d;
            b_q             <= b_d;
            data_in_q       <= data_in_d;
            start_q         <= start_d;
            busy_q          <= busy_d;
            out_valid_q     <= out_valid_d;
            out_err_q       <= out_err_d;
            out_product_q   <= out_product_d;
            done_low_seen_q <= done_low_seen_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.start       = start_q;
    assign bus.data_in     = data_in_q;
    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_err     = out_err_q;
    assign bus.out_product = out_product_q;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Bench for booth_operand_sequencer: a cycle-driven multiplier stub plus
// expected products computed as plain signed multiplication of the operands.
module tb_booth_operand_sequencer;

    localparam int W       = 16;
    localparam int TIMEOUT = 40;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    booth_seq_if #(.W(W)) bus ();

    booth_operand_sequencer #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.done      = 1'b0;
        bus.product   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.start, bus.data_in, bus.out_valid, bus.out_product, bus.out_err, bus.busy} !== '0)
            $display("FAIL reset_outputs: got start=%b data_in=%h out_valid=%b out_product=%h out_err=%b busy=%b, want all 0",
                     bus.start, bus.data_in, bus.out_valid, bus.out_product, bus.out_err, bus.busy);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100)
            $display("FAIL reset_release: got in_ready/busy/out_valid=%b want 100",
                     {bus.in_ready, bus.busy, bus.out_valid});
        else pass_cnt++;
    endtask

    // One full operation. Cycle c=0 is the START cycle. The stub drives done high
    // for c < stale_n (left over from a previous op) and again from c >= rise_c.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stale_n,
                         input int rise_c, input int stall, input bit expect_to,
                         input string nm);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [31:0] ep;
        logic signed [15:0] ms = '0;
        logic signed [15:0] qs = '0;
        logic signed [31:0] sp;
        logic        [18:0] want;
        logic        [18:0] obs;
        logic        [31:0] exp_p;
        int                 c;
        int                 n;
        int                 exp_c;
        bit                 got;

        sa    = a;
        sb    = b;
        ep    = sa * sb;
        exp_p = expect_to ? 32'h0 : ep;
        exp_c = expect_to ? (3 + TIMEOUT) : (rise_c + 1);

        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            chk_cnt++;
            $display("FAIL %s in_ready: got 0 for 50 cycles want 1", nm);
            return;
        end

        bus.done     = (stale_n > 0);
        bus.product  = 32'hDEADBEEF;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);

        c   = 0;
        got = 1'b0;
        while (!got && c < 200) begin
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                case (c)
                    0:       want = {1'b1, 16'h0000, 1'b1, 1'b0};
                    1:       want = {1'b0, a, 1'b1, 1'b0};
                    2:       want = {1'b0, b, 1'b1, 1'b0};
                    default: want = {1'b0, 16'h0000, 1'b1, 1'b0};
                endcase
                obs = {bus.start, bus.data_in, bus.busy, bus.in_ready};
                chk_cnt++;
                if (obs !== want)
                    $display("FAIL %s cyc%0d start/data_in/busy/in_ready: got %h want %h",
                             nm, c, obs, want);
                else pass_cnt++;
                if (c == 1) ms = bus.data_in;
                if (c == 2) qs = bus.data_in;
                sp          = ms * qs;
                bus.done    = (c < stale_n) || (c >= rise_c);
                bus.product = (c >= rise_c) ? sp : 32'hDEADBEEF;
                @(negedge clk);
                c++;
            end
        end
        bus.done = 1'b0;

        chk_cnt++;
        if (!got || c != exp_c) begin
            $display("FAIL %s out_valid_cycle: got %0d (seen=%0d) want %0d", nm, c, got, exp_c);
            return;
        end
        pass_cnt++;

        chk_cnt++;
        if ({bus.out_product, bus.out_err, bus.in_ready, bus.busy} !== {exp_p, expect_to, 1'b0, 1'b1})
            $display("FAIL %s result: got product=%h err=%b in_ready=%b busy=%b want product=%h err=%b in_ready=0 busy=1",
                     nm, bus.out_product, bus.out_err, bus.in_ready, bus.busy, exp_p, expect_to);
        else pass_cnt++;

        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            @(negedge clk);
            chk_cnt++;
            if ({bus.out_valid, bus.out_product, bus.out_err, bus.in_ready} !== {1'b1, exp_p, expect_to, 1'b0})
                $display("FAIL %s hold%0d: got valid=%b product=%h err=%b in_ready=%b want valid=1 product=%h err=%b in_ready=0",
                         nm, s, bus.out_valid, bus.out_product, bus.out_err, bus.in_ready, exp_p, expect_to);
            else pass_cnt++;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010)
            $display("FAIL %s release: got out_valid/in_ready/busy=%b want 010",
                     nm, {bus.out_valid, bus.in_ready, bus.busy});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_op(16'd17, 16'd5, 0, 5, 0, 1'b0, "basic");
    endtask

    task automatic test_signed();
        do_op(16'hFFFD, 16'd7, 0, 3, 2, 1'b0, "signed");
        do_op(16'h8000, 16'h8000, 0, 4, 0, 1'b0, "min_x_min");
    endtask

    task automatic test_backpressure();
        do_op(16'($urandom), 16'($urandom), 0, 6, 10, 1'b0, "backpressure");
    endtask

    task automatic test_timeout();
        do_op(16'd9, 16'd9, 0, 1000, 1, 1'b1, "timeout");
        do_op(16'd11, 16'd3, 0, 3 + TIMEOUT - 1, 0, 1'b0, "done_at_last_cycle");
        do_op(16'd11, 16'd3, 0, 3 + TIMEOUT, 0, 1'b1, "done_after_timeout");
    endtask

    task automatic test_stale_done();
        do_op(16'd100, 16'hFFFF, 2, 22, 0, 1'b0, "stale_drop_at_ldq");
        do_op(16'd45, 16'd45, 6, 12, 0, 1'b0, "stale_into_wait");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
                  3 + int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.done     = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (bus.busy !== 1'b1)
            $display("FAIL reset_mid_busy: got %b want 1", bus.busy);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({bus.start, bus.data_in, bus.out_valid, bus.out_product, bus.out_err, bus.busy} !== '0)
            $display("FAIL reset_mid_outputs: got start=%b data_in=%h out_valid=%b out_product=%h out_err=%b busy=%b, want all 0",
                     bus.start, bus.data_in, bus.out_valid, bus.out_product, bus.out_err, bus.busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.in_ready, bus.busy} !== 2'b10)
            $display("FAIL reset_mid_release: got in_ready/busy=%b want 10", {bus.in_ready, bus.busy});
        else pass_cnt++;
        do_op(16'd2, 16'd3, 0, 4, 1, 1'b0, "after_reset");
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
